// File: rtl/hook_pkg.sv
// Shared types and constants for the hook launch sequencer: FSM states,
// object classes and the per-class score lookup.
package hook_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LAUNCH,
    EXTEND,
    RETRACT,
    COOLDOWN
  } hook_state_t;

  localparam logic [1:0] CLASS_NONE  = 2'd0;
  localparam logic [1:0] CLASS_SMALL = 2'd1;
  localparam logic [1:0] CLASS_BIG   = 2'd2;
  localparam logic [1:0] CLASS_ROCK  = 2'd3;

  localparam int unsigned SCORE_SMALL_DEF = 10;
  localparam int unsigned SCORE_BIG_DEF   = 50;
  localparam int unsigned SCORE_ROCK_DEF  = 2;

  function automatic logic [7:0] class_to_score(input logic [1:0] cls,
                                                input logic [7:0] s_small,
                                                input logic [7:0] s_big,
                                                input logic [7:0] s_rock);
    case (cls)
      CLASS_SMALL: class_to_score = s_small;
      CLASS_BIG:   class_to_score = s_big;
      CLASS_ROCK:  class_to_score = s_rock;
      default:     class_to_score = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: remembers the previous level in a register and
// flags the cycle where the input is high but was low before.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/hook_launch_controller.sv
// Launch/extend/retract sequencer for the cable mover: debounces the launch
// key into one request, forces returns, and reports the grabbed score.
module hook_launch_controller
  import hook_pkg::*;
#(
  parameter int unsigned MAX_EXTEND_FRAMES     = 90,
  parameter int unsigned LAUNCH_TIMEOUT_FRAMES = 4,
  parameter int unsigned COOLDOWN_FRAMES       = 8,
  parameter int unsigned SCORE_SMALL           = SCORE_SMALL_DEF,
  parameter int unsigned SCORE_BIG             = SCORE_BIG_DEF,
  parameter int unsigned SCORE_ROCK            = SCORE_ROCK_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       launchKey,
  input  logic       IsInCircular,
  input  logic       hitObject,
  input  logic [1:0] objectClass,
  input  logic       hitEdge,
  output logic       launch_Cable,
  output logic       collision,
  output logic       busy,
  output logic [1:0] grabbedClass,
  output logic       scoreValid,
  output logic [7:0] scoreAdd
);

  localparam logic [7:0] MAX_EXT = 8'(MAX_EXTEND_FRAMES);
  localparam logic [7:0] LAUNCH_TO = 8'(LAUNCH_TIMEOUT_FRAMES);
  localparam logic [7:0] COOL = 8'(COOLDOWN_FRAMES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  hook_state_t state;
  logic [7:0]  cnt;
  logic        key_r;
  logic        key_rise;
  logic        circ_rise;
  logic [7:0]  cnt_inc;

  // The key is registered before edge detection, so an edge arms two cycles later.
  always_ff @(posedge clk) begin
    if (resetN) key_r <= 1'b0;
    else        key_r <= launchKey;
  end

  edge_detect u_key_edge (
    .clk  (clk),
    .rst  (resetN),
    .d    (key_r),
    .rise (key_rise)
  );

  edge_detect u_circ_edge (
    .clk  (clk),
    .rst  (resetN),
    .d    (IsInCircular),
    .rise (circ_rise)
  );

  assign cnt_inc = sat_inc(cnt);

  always_ff @(posedge clk) begin
    if (resetN) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      launch_Cable <= 1'b0;
      collision    <= 1'b0;
      busy         <= 1'b0;
      grabbedClass <= CLASS_NONE;
      scoreValid   <= 1'b0;
      scoreAdd     <= 8'd0;
    end else begin
      collision  <= 1'b0;
      scoreValid <= 1'b0;
      scoreAdd   <= 8'd0;
      if (startOfFrame) cnt <= cnt_inc;
      case (state)
        IDLE: begin
          if (key_rise && IsInCircular) begin
            state <= ARMED;
            cnt   <= 8'd0;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (startOfFrame) begin
            state        <= LAUNCH;
            cnt          <= 8'd0;
            launch_Cable <= 1'b1;
          end
        end
        LAUNCH: begin
          if (!IsInCircular) begin
            state        <= EXTEND;
            cnt          <= 8'd0;
            launch_Cable <= 1'b0;
          end else if (startOfFrame && cnt_inc >= LAUNCH_TO) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            launch_Cable <= 1'b0;
            busy         <= 1'b0;
          end
        end
        EXTEND: begin
          // Object beats edge beats timeout; only an object hit carries a class.
          if (hitObject || hitEdge || (startOfFrame && cnt_inc >= MAX_EXT)) begin
            state        <= RETRACT;
            cnt          <= 8'd0;
            collision    <= 1'b1;
            grabbedClass <= hitObject ? objectClass : CLASS_NONE;
          end
        end
        RETRACT: begin
          if (circ_rise) begin
            state <= COOLDOWN;
            cnt   <= 8'd0;
            if (grabbedClass != CLASS_NONE) begin
              scoreValid <= 1'b1;
              scoreAdd   <= class_to_score(grabbedClass, 8'(SCORE_SMALL),
                                           8'(SCORE_BIG), 8'(SCORE_ROCK));
            end
          end
        end
        COOLDOWN: begin
          if (startOfFrame && cnt_inc >= COOL) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            busy         <= 1'b0;
            grabbedClass <= CLASS_NONE;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= 8'd0;
          launch_Cable <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hook_launch_controller.sv
// Bench for hook_launch_controller: directed scenarios followed by random
// traffic, every cycle compared against a trip-level reference model.
module tb_hook_launch_controller;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       launchKey = 1'b0;
  logic       IsInCircular = 1'b1;
  logic       hitObject = 1'b0;
  logic [1:0] objectClass = 2'd0;
  logic       hitEdge = 1'b0;
  logic       launch_Cable;
  logic       collision;
  logic       busy;
  logic [1:0] grabbedClass;
  logic       scoreValid;
  logic [7:0] scoreAdd;

  int passed = 0;
  int total = 0;
  int launches = 0;
  logic prev_cable = 1'b0;

  always #5 clk = ~clk;

  hook_launch_controller dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .launchKey    (launchKey),
    .IsInCircular (IsInCircular),
    .hitObject    (hitObject),
    .objectClass  (objectClass),
    .hitEdge      (hitEdge),
    .launch_Cable (launch_Cable),
    .collision    (collision),
    .busy         (busy),
    .grabbedClass (grabbedClass),
    .scoreValid   (scoreValid),
    .scoreAdd     (scoreAdd)
  );

  // Reference model: a trip is described by its phase name and frames seen.
  string      phase = "idle";
  int         frames = 0;
  int         grab = 0;
  bit         key_seen1 = 0, key_seen2 = 0, circ_seen = 0;
  bit         e_cable = 0, e_coll = 0, e_score = 0;
  int         e_add = 0;

  function automatic int score_of(int cls);
    if (cls == 1) return 10;
    if (cls == 2) return 50;
    if (cls == 3) return 2;
    return 0;
  endfunction

  task automatic model_step();
    bit key_edge, circ_up;
    e_coll = 0;
    e_score = 0;
    e_add = 0;
    if (resetN) begin
      phase = "idle"; frames = 0; grab = 0; e_cable = 0;
      key_seen1 = 0; key_seen2 = 0; circ_seen = 0;
      return;
    end
    key_edge = key_seen1 && !key_seen2;
    circ_up = IsInCircular && !circ_seen;
    key_seen2 = key_seen1;
    key_seen1 = launchKey;
    circ_seen = IsInCircular;
    if (phase == "idle") begin
      if (key_edge && IsInCircular) phase = "armed";
    end else if (phase == "armed") begin
      if (startOfFrame) begin phase = "launch"; frames = 0; e_cable = 1; end
    end else if (phase == "launch") begin
      if (!IsInCircular) begin phase = "extend"; frames = 0; e_cable = 0; end
      else if (startOfFrame) begin
        frames++;
        if (frames >= 4) begin phase = "idle"; e_cable = 0; end
      end
    end else if (phase == "extend") begin
      if (startOfFrame) frames++;
      if (hitObject) begin phase = "retract"; e_coll = 1; grab = objectClass; end
      else if (hitEdge || frames >= 90) begin phase = "retract"; e_coll = 1; grab = 0; end
    end else if (phase == "retract") begin
      if (circ_up) begin
        phase = "cooldown"; frames = 0;
        if (grab != 0) begin e_score = 1; e_add = score_of(grab); end
      end
    end else begin
      if (startOfFrame) frames++;
      if (frames >= 8) begin phase = "idle"; grab = 0; frames = 0; end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("launch_Cable", 8'(launch_Cable), 8'(e_cable));
      chk("collision", 8'(collision), 8'(e_coll));
      chk("busy", 8'(busy), 8'(phase != "idle"));
      chk("grabbedClass", 8'(grabbedClass), 8'(grab));
      chk("scoreValid", 8'(scoreValid), 8'(e_score));
      chk("scoreAdd", 8'(scoreAdd), 8'(e_add));
      if (launch_Cable && !prev_cable) launches++;
      prev_cable = launch_Cable;
    end
  endtask

  task automatic frame_pulses(input int n, input int gap = 4);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick(gap - 1);
    end
  endtask

  task automatic press_key();
    launchKey = 1'b1;
    tick(3);
    launchKey = 1'b0;
    tick(2);
  endtask

  initial begin
    resetN = 1'b1;
    tick(3);
    resetN = 1'b0;
    tick(2);

    // Launch handshake, then big grab with simultaneous edge hit
    IsInCircular = 1'b1;
    press_key();
    frame_pulses(2);
    IsInCircular = 1'b0;
    tick(3);
    hitObject = 1'b1; objectClass = 2'd2; hitEdge = 1'b1;
    tick();
    hitObject = 1'b0; objectClass = 2'd0; hitEdge = 1'b0;
    tick(3);
    hitEdge = 1'b1;
    press_key();
    hitEdge = 1'b0;
    IsInCircular = 1'b1;
    tick(4);
    // Edges during cooldown are ignored; the first after 8 frames arms
    press_key();
    frame_pulses(3);
    press_key();
    frame_pulses(5);
    tick(2);
    press_key();
    frame_pulses(1);

    // Extend timeout with no hits
    IsInCircular = 1'b0;
    tick(2);
    frame_pulses(91, 3);
    IsInCircular = 1'b1;
    tick(3);
    frame_pulses(9);

    // Launch timeout: mover never leaves circular motion
    press_key();
    frame_pulses(6);

    // Reset for 3 cycles mid-extend, then a fresh key edge is accepted
    press_key();
    frame_pulses(1);
    IsInCircular = 1'b0;
    frame_pulses(3);
    resetN = 1'b1;
    tick(3);
    resetN = 1'b0;
    IsInCircular = 1'b1;
    tick(2);
    press_key();
    frame_pulses(1);
    IsInCircular = 1'b0;
    tick(2);
    hitObject = 1'b1; objectClass = 2'd1;
    tick();
    hitObject = 1'b0;
    IsInCircular = 1'b1;
    tick(2);
    frame_pulses(9);

    // Key held for 200 frames gives exactly one launch
    launches = 0;
    launchKey = 1'b1;
    frame_pulses(200);
    launchKey = 1'b0;
    tick(2);
    chk("hold_key_launches", 8'(launches), 8'd1);

    // Random traffic
    for (int c = 0; c < 20000; c++) begin
      resetN = ($urandom_range(999) == 0);
      startOfFrame = ($urandom_range(2) == 0);
      if ($urandom_range(7) == 0) launchKey = ~launchKey;
      if ($urandom_range(19) == 0) IsInCircular = ~IsInCircular;
      hitObject = ($urandom_range(39) == 0);
      objectClass = 2'($urandom_range(3));
      hitEdge = ($urandom_range(59) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
